// File: rtl/eth_ctrl_pkg.sv
// Shared definitions for the Ethernet controller config-port blocks:
// FSM state encoding, timing defaults and the error-response data value.
package eth_ctrl_pkg;

    // Arbiter FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT_WR = 3'd2;
    localparam logic [2:0] ST_WAIT_RD = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // Post-write settle time; the config port gives no write acknowledge
    localparam int DEF_WR_GAP     = 16;
    // Longest wait for usr_rd_vld before a read is failed
    localparam int DEF_RD_TIMEOUT = 256;
    // Data returned alongside an error response
    localparam int ERR_DATA       = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_cfg_arb_if.sv
// User register-config port of the Ethernet controller.
// master = the side issuing accesses, slave = the controller returning read data.
interface eth_cfg_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              usr_cfg_type;
    logic              usr_wr_en;
    logic [ADDR_W-1:0] usr_wr_addr;
    logic [DATA_W-1:0] usr_wr_data;
    logic              usr_rd_en;
    logic [ADDR_W-1:0] usr_rd_addr;
    logic              usr_rd_vld;
    logic [DATA_W-1:0] usr_rd_data;

    modport master (
        output usr_cfg_type,
        output usr_wr_en,
        output usr_wr_addr,
        output usr_wr_data,
        output usr_rd_en,
        output usr_rd_addr,
        input  usr_rd_vld,
        input  usr_rd_data
    );

    modport slave (
        input  usr_cfg_type,
        input  usr_wr_en,
        input  usr_wr_addr,
        input  usr_wr_data,
        input  usr_rd_en,
        input  usr_rd_addr,
        output usr_rd_vld,
        output usr_rd_data
    );
endinterface

// File: rtl/eth_rr_arb.sv
// Combinational round-robin picker: first active request strictly after
// last_i, wrapping modulo NUM_REQ. Produces one-hot grant plus its index.
module eth_rr_arb #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    // Walk positions last_i+1 .. last_i+NUM_REQ; the first hit wins
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] pos;
        cand      = 0;
        pos       = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            pos = IDX_W'(cand);
            if (!gnt_vld_o && req_i[pos]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = pos;
                gnt_o     = NUM_REQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/eth_cfg_arb.sv
// Shares the single user register-config port between NUM_REQ requesters.
// Round-robin grant, one transaction in flight, fixed gap after writes,
// bounded wait for read data. Every output is driven from a register.
module eth_cfg_arb
    import eth_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int WR_GAP         = DEF_WR_GAP,
    parameter int RD_TIMEOUT     = DEF_RD_TIMEOUT
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_aresetn,
    input  logic                               eth_init_done,
    input  logic [NUM_REQ-1:0]                 req_vld,
    input  logic [NUM_REQ-1:0]                 req_wr,
    input  logic [NUM_REQ-1:0]                 req_type,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 rsp_vld,
    output logic                               rsp_err,
    output logic [REG_DATA_WIDTH-1:0]          rsp_data,
    output logic                               busy,
    eth_cfg_arb_if.master                      usr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Counter must reach both WR_GAP-1 and RD_TIMEOUT-1
    localparam int CNT_W = $clog2(max_int(WR_GAP, RD_TIMEOUT));

    // Unpacked views of the packed request buses
    logic [REG_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [REG_DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign data_arr[i] = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
    end

    logic [2:0]                state_q, state_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic [IDX_W-1:0]          gidx_q, gidx_d;
    logic                      wr_q, wr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]        ack_q, ack_d;
    logic [NUM_REQ-1:0]        rsp_vld_q, rsp_vld_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [REG_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      busy_q, busy_d;
    logic                      type_q, type_d;
    logic                      wr_en_q, wr_en_d;
    logic                      rd_en_q, rd_en_d;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [REG_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_vld;
    logic                      grant_ok;
    logic [NUM_REQ-1:0]        g_oh;
    logic                      wr_done;
    logic                      rd_timeout;

    eth_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req_i     (req_vld),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    // New grants are held off until the controller has finished initialising
    assign grant_ok   = eth_init_done & arb_vld;
    assign g_oh       = NUM_REQ'(1) << gidx_q;
    assign wr_done    = (cnt_q == CNT_W'(WR_GAP - 1));
    assign rd_timeout = (cnt_q == CNT_W'(RD_TIMEOUT - 1));

    // State, bookkeeping and output registers; async reset clears all
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(NUM_REQ - 1);
            gidx_q     <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            busy_q     <= 1'b0;
            type_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gidx_q     <= gidx_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
            busy_q     <= busy_d;
            type_q     <= type_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant_ok) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = wr_q ? ST_WAIT_WR : ST_WAIT_RD;
            ST_WAIT_WR: if (wr_done) state_d = ST_RESP;
            ST_WAIT_RD: if (usr.usr_rd_vld || rd_timeout) state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; pulses are computed one cycle ahead so
    // that their registered copies line up with the ISSUE and RESP states
    always_comb begin
        last_d     = last_q;
        gidx_d     = gidx_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rsp_vld_d  = '0;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        type_d     = type_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        busy_d     = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    gidx_d = arb_idx;
                    wr_d   = req_wr[arb_idx];
                    type_d = req_type[arb_idx];
                    ack_d  = arb_gnt;
                    cnt_d  = '0;
                    if (req_wr[arb_idx]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_arr[arb_idx];
                        wr_data_d = data_arr[arb_idx];
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_arr[arb_idx];
                    end
                end
            end
            ST_ISSUE: begin
                // Read data arriving this cycle is not accepted yet
                last_d = gidx_q;
                cnt_d  = '0;
            end
            ST_WAIT_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wr_done) begin
                    rsp_vld_d  = g_oh;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                    cnt_d      = '0;
                end
            end
            ST_WAIT_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Real data beats the timeout when both land together
                if (usr.usr_rd_vld) begin
                    rsp_vld_d  = g_oh;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = usr.usr_rd_data;
                    cnt_d      = '0;
                end else if (rd_timeout) begin
                    rsp_vld_d  = g_oh;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = REG_DATA_WIDTH'(ERR_DATA);
                    cnt_d      = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign req_ack          = ack_q;
    assign rsp_vld          = rsp_vld_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_data         = rsp_data_q;
    assign busy             = busy_q;
    assign usr.usr_cfg_type = type_q;
    assign usr.usr_wr_en    = wr_en_q;
    assign usr.usr_wr_addr  = wr_addr_q;
    assign usr.usr_wr_data  = wr_data_q;
    assign usr.usr_rd_en    = rd_en_q;
    assign usr.usr_rd_addr  = rd_addr_q;

endmodule
